alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- EX/MEM boundary register directly downstream of the ALU.
- Captures ALU Out/Zero plus the memory/writeback control bits travelling with the instruction, and resolves beq (Branch && Zero).
- Presents the result to the MEM stage over a valid/ready handshake.
- A 2-entry skid buffer lets upstream see a registered ready, with no combinational path from OutReady to InReady.

Parameters:
DATA_WIDTH, 32, width of ALU result, store data and branch target
REG_ADDR_WIDTH, 5, width of destination register index

Ports:
Clock  input  1  single clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Flush  input  1  synchronous squash of all held entries (branch mispredict/exception)
InValid  input  1  upstream (EX) has an instruction this cycle
InReady  output  1  stage can accept; registered
AluOut  input  DATA_WIDTH  ALU result
AluZero  input  1  ALU zero flag
StoreData  input  DATA_WIDTH  rt value for sw
BranchTarget  input  DATA_WIDTH  PC+4+(imm<<2)
DestReg  input  REG_ADDR_WIDTH  writeback register index
CtrlIn  input  5  {Branch, MemRead, MemWrite, MemToReg, RegWrite}
OutValid  output  1  head entry valid
OutReady  input  1  MEM stage accepts head
Result  output  DATA_WIDTH  head AluOut
StoreDataOut  output  DATA_WIDTH  head StoreData
DestRegOut  output  REG_ADDR_WIDTH  head DestReg
CtrlOut  output  4  head {MemRead, MemWrite, MemToReg, RegWrite}
BranchTaken  output  1  head Branch && AluZero, captured at accept
BranchAddr  output  DATA_WIDTH  head BranchTarget

Behaviour:
- Accept: InValid && InReady at a rising edge. Pop: OutValid && OutReady at a rising edge.
- Storage: head register drives the outputs; skid register holds the second entry. FIFO order is strictly preserved.
- States and transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept with pop -> ONE (new entry becomes head).
  - FULL: pop -> ONE (skid moves to head); accept is impossible.
- InReady: registered; 1 in EMPTY and ONE, 0 in FULL.
- Latency: an entry accepted at edge N is visible on the outputs after edge N (OutValid=1 in cycle N+1) when the stage was EMPTY, or when ONE with a simultaneous pop.
- Throughput: one instruction per cycle with OutReady held high.
- BranchTaken is computed from the captured Branch and AluZero at accept and stored per entry, never from live inputs.
- While OutValid=0:
  - BranchTaken reads 0.
  - CtrlOut reads 0 (prevents a spurious write in MEM).
  - Result, StoreDataOut, DestRegOut and BranchAddr hold their last values.
- Flush: next state EMPTY, InReady=1. Flush has priority over a same-cycle accept and pop; the incoming instruction is dropped. Data registers are not cleared.
- Reset (synchronous): state EMPTY, OutValid=0, InReady=1, all data outputs 0, BranchTaken=0, CtrlOut=0. Reset beats Flush. Reset mid-stream discards both entries.
- OutReady may toggle freely while OutValid=1; head data must stay stable until popped.
- InValid && !InReady: no capture; upstream must hold its data.

Optional Feature:
ALU_RESULT_STAGE_PERF_EN:
- Defined: adds output StallCount (32 bits), the number of cycles with OutValid && !OutReady. Saturates at 0xFFFFFFFF. Cleared by Reset only (not by Flush).
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset held 2 cycles, then released -> OutValid=0, InReady=1, Result=0, CtrlOut=0.
- Streaming: InValid=1 and OutReady=1 for 4 cycles with AluOut=10,20,30,40 -> Result shows 10,20,30,40 on consecutive cycles starting 1 cycle after the first accept; InReady stays 1.
- Backpressure: OutReady=0, push AluOut=0xA then 0xB -> after the second accept InReady=0 and Result=0xA. Raise OutReady -> Result=0xA, then 0xB, then OutValid=0; no entry lost or duplicated.
- Branch: CtrlIn Branch=1 with AluZero=1 and BranchTarget=0x40 -> BranchTaken=1, BranchAddr=0x40. Same with AluZero=0 -> BranchTaken=0. CtrlOut excludes Branch.
- Flush while FULL with InValid=1 -> next cycle OutValid=0, InReady=1, CtrlOut=0; the next accepted AluOut=0x77 appears as Result=0x77.
- PERF_EN build: OutValid=1 with OutReady=0 for 5 cycles -> StallCount=5; Flush leaves it 5; Reset -> 0.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: EX/MEM boundary register with a 2-entry skid buffer; resolves beq at accept.
// Latency: 1 cycle from accept to OutValid when EMPTY, or when ONE with a same-cycle pop.
// Backpressure: InReady is registered (low only when both entries are held); no OutReady->InReady path.
//
// Ports:
//   Clock, Reset (sync, active-high), Flush (sync squash of held entries)
//   InValid/InReady     : upstream handshake carrying AluOut, AluZero, StoreData,
//                         BranchTarget, DestReg, CtrlIn = {Branch, MemRead, MemWrite, MemToReg, RegWrite}
//   OutValid/OutReady   : downstream handshake carrying Result, StoreDataOut, DestRegOut,
//                         CtrlOut = {MemRead, MemWrite, MemToReg, RegWrite}, BranchTaken, BranchAddr
//   StallCount          : only when ALU_RESULT_STAGE_PERF_EN is defined; saturating count of
//                         cycles with OutValid && !OutReady, cleared by Reset only.
module alu_result_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Flush,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [DATA_WIDTH-1:0]     AluOut,
    input  logic                      AluZero,
    input  logic [DATA_WIDTH-1:0]     StoreData,
    input  logic [DATA_WIDTH-1:0]     BranchTarget,
    input  logic [REG_ADDR_WIDTH-1:0] DestReg,
    input  logic [4:0]                CtrlIn,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [DATA_WIDTH-1:0]     Result,
    output logic [DATA_WIDTH-1:0]     StoreDataOut,
    output logic [REG_ADDR_WIDTH-1:0] DestRegOut,
    output logic [3:0]                CtrlOut,
    output logic                      BranchTaken,
    output logic [DATA_WIDTH-1:0]     BranchAddr
`ifdef ALU_RESULT_STAGE_PERF_EN
    ,
    output logic [31:0]               StallCount
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] dest_reg;
        logic [3:0]                ctrl;
        logic                      br_taken;
        logic [DATA_WIDTH-1:0]     br_addr;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;

    entry_t in_entry;
    logic   out_valid;
    logic   accept;
    logic   pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = InValid && in_ready_q;
    assign pop       = out_valid && OutReady;

    always_comb begin
        in_entry            = '0;
        in_entry.result     = AluOut;
        in_entry.store_data = StoreData;
        in_entry.dest_reg   = DestReg;
        in_entry.ctrl       = CtrlIn[3:0];
        // Branch resolution is frozen into the entry so later AluZero changes cannot affect it.
        in_entry.br_taken   = CtrlIn[4] && AluZero;
        in_entry.br_addr    = BranchTarget;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (Flush) begin
            // Squash only the occupancy; data registers keep their contents.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        head_d  = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready_q is low here, so no accept can coincide with the pop.
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign InReady      = in_ready_q;
    assign OutValid     = out_valid;
    assign Result       = head_q.result;
    assign StoreDataOut = head_q.store_data;
    assign DestRegOut   = head_q.dest_reg;
    assign BranchAddr   = head_q.br_addr;
    // Control and branch outcome are gated so a stale head can never trigger a MEM write or redirect.
    assign CtrlOut      = out_valid ? head_q.ctrl : 4'b0000;
    assign BranchTaken  = out_valid && head_q.br_taken;

`ifdef ALU_RESULT_STAGE_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (out_valid && !OutReady && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign StallCount = stall_count_q;
`endif

endmodule
